// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Provides the FSM state encoding and the add/subtract mode codes.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_fa_bit.sv
// Single-bit full adder, the one arithmetic cell reused every cycle
// by serial_addsub.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract core: one full adder, LSB first, WIDTH cycles per op.
// Define SERIAL_ADDSUB_SAT_EN to clamp overflowing results to the signed limit.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] sha;
  logic [WIDTH-1:0] shb;
  logic [WIDTH-2:0] res;

  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             ovf_nxt;

  fa_bit u_fa (
    .a  (sha[0]),
    .b  (shb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last    = (cnt == CW'(WIDTH - 1));
  assign accept  = (state == IDLE) && start;
  assign res_nxt = {fa_s, res};
  // On the MSB cycle the carry register holds the carry into the MSB.
  assign ovf_nxt = carry ^ fa_co;

`ifdef SERIAL_ADDSUB_SAT_EN
  function automatic logic [WIDTH-1:0] sat_result(
    input logic [WIDTH-1:0] wrapped,
    input logic             ov,
    input logic             a_msb
  );
    if (!ov)
      return wrapped;
    // Overflow implies the true sign equals A's sign.
    return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  assign sum_nxt = sat_result(res_nxt, ovf_nxt, sha[0]);
`else
  assign sum_nxt = res_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Control and committed-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= mode;
    end else if (state == RUN) begin
      cnt   <= cnt + 1'b1;
      carry <= fa_co;
      if (last) begin
        sum  <= sum_nxt;
        cout <= fa_co;
        ovf  <= ovf_nxt;
      end
    end
  end

  // Operand and partial-result shift registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      sha <= a;
      shb <= (mode == MODE_SUB) ? ~b : b;
    end else if (state == RUN) begin
      sha <= sha >> 1;
      shb <= shb >> 1;
      res <= res_nxt[WIDTH-1:1];
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=8); honours SERIAL_ADDSUB_SAT_EN.
module tb_serial_addsub;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic         clk = 1'b0;
  logic         rst, start, mode;
  logic [W-1:0] a, b, sum;
  logic         busy, done, cout, ovf;

  res_t exp_q[$];
  res_t snap;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    logic [W:0] full;
    res_t r;
    if (!m) full = {1'b0, x} + {1'b0, y};
    else    full = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    if (!m) r.ovf = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    else    r.ovf = (x[W-1] != y[W-1]) && (r.sum[W-1] != x[W-1]);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (r.ovf) r.sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return r;
  endfunction

  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    @(negedge clk);
    a = x; b = y; mode = m; start = 1'b1;
    snap = {sum, cout, ovf};
    exp_q.push_back(model(x, y, m));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges until done, busy cycles, overlap and result changes during RUN.
  task automatic wait_done(output int lat, output int bc, output bit both,
                           output bit chg, output bit got);
    lat = 0; bc = 0; both = 0; chg = 0; got = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (busy && done) both = 1;
      if (busy) begin
        bc++;
        if ({sum, cout, ovf} !== snap) chg = 1;
      end
      if (done) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_tests++; if (sum !== '0)    begin n_fail++; $display("FAIL reset_sum got %h exp 00", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %b exp 0", cout); end
    n_tests++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [W-1:0] va[3] = '{8'h0F, 8'hFF, 8'h7F};
    logic [W-1:0] vb[3] = '{8'hF0, 8'h01, 8'h01};
    int lat, bc;
    bit both, chg, got;
    res_t e;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], 1'b0);
      wait_done(lat, bc, both, chg, got);
      n_tests++;
      if (!got) begin
        n_fail++; $display("FAIL add_timeout[%0d] done=0 after %0d cycles exp pulse at 9", i, lat);
        exp_q.delete();
        continue;
      end
      e = exp_q.pop_front();
      n_tests++; if (sum !== e.sum)   begin n_fail++; $display("FAIL add_sum[%0d] got %h exp %h", i, sum, e.sum); end
      n_tests++; if (cout !== e.cout) begin n_fail++; $display("FAIL add_cout[%0d] got %b exp %b", i, cout, e.cout); end
      n_tests++; if (ovf !== e.ovf)   begin n_fail++; $display("FAIL add_ovf[%0d] got %b exp %b", i, ovf, e.ovf); end
      n_tests++; if (lat !== 9)       begin n_fail++; $display("FAIL add_latency[%0d] got %0d exp 9", i, lat); end
      n_tests++; if (bc !== 8)        begin n_fail++; $display("FAIL add_busy_cycles[%0d] got %0d exp 8", i, bc); end
      n_tests++; if (both !== 1'b0)   begin n_fail++; $display("FAIL add_busy_done_overlap[%0d] got 1 exp 0", i); end
      n_tests++; if (chg !== 1'b0)    begin n_fail++; $display("FAIL add_result_moved_in_run[%0d] got 1 exp 0", i); end
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] va[3] = '{8'h05, 8'h80, 8'h40};
    logic [W-1:0] vb[3] = '{8'h07, 8'h01, 8'h40};
    int lat, bc;
    bit both, chg, got;
    res_t e;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], 1'b1);
      wait_done(lat, bc, both, chg, got);
      n_tests++;
      if (!got) begin
        n_fail++; $display("FAIL sub_timeout[%0d] done=0 after %0d cycles exp pulse at 9", i, lat);
        exp_q.delete();
        continue;
      end
      e = exp_q.pop_front();
      n_tests++; if (sum !== e.sum)   begin n_fail++; $display("FAIL sub_sum[%0d] got %h exp %h", i, sum, e.sum); end
      n_tests++; if (cout !== e.cout) begin n_fail++; $display("FAIL sub_cout[%0d] got %b exp %b", i, cout, e.cout); end
      n_tests++; if (ovf !== e.ovf)   begin n_fail++; $display("FAIL sub_ovf[%0d] got %b exp %b", i, ovf, e.ovf); end
      n_tests++; if (lat !== 9)       begin n_fail++; $display("FAIL sub_latency[%0d] got %0d exp 9", i, lat); end
    end
  endtask

  task automatic test_ignore_start();
    int  lat = 0, bc = 0, nd = 0, nb = 0;
    bit  got = 0, injected = 0;
    res_t e;
    launch(8'h11, 8'h22, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      lat++;
      if (start) start = 1'b0;
      if (busy) bc++;
      if (done) begin got = 1; break; end
      if (bc == 3 && !injected) begin
        a = 8'hAA; b = 8'h55; mode = 1'b1; start = 1'b1; injected = 1;
      end
    end
    start = 1'b0;
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL ignore_timeout done=0 after %0d cycles exp pulse at 9", lat);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      n_tests++; if (sum !== e.sum)   begin n_fail++; $display("FAIL ignore_sum got %h exp %h", sum, e.sum); end
      n_tests++; if (cout !== e.cout) begin n_fail++; $display("FAIL ignore_cout got %b exp %b", cout, e.cout); end
      n_tests++; if (lat !== 9)       begin n_fail++; $display("FAIL ignore_latency got %0d exp 9", lat); end
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL ignore_extra_done got %0d pulses exp 0", nd); end
    n_tests++; if (nb !== 0) begin n_fail++; $display("FAIL ignore_extra_busy got %0d cycles exp 0", nb); end
  endtask

  task automatic test_reset_mid_run();
    int  bc = 0, nd = 0, lat, bc2;
    bit  both, chg, got;
    res_t e;
    launch(8'h33, 8'h44, 1'b0);
    for (int i = 0; i < 20 && bc < 4; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b exp 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b exp 0", done); end
    n_tests++; if (sum !== '0)    begin n_fail++; $display("FAIL midrst_sum got %h exp 00", sum); end
    n_tests++; if (cout !== 1'b0) begin n_fail++; $display("FAIL midrst_cout got %b exp 0", cout); end
    n_tests++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL midrst_ovf got %b exp 0", ovf); end
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    n_tests++; if (nd !== 0) begin n_fail++; $display("FAIL midrst_aborted_done got %0d pulses exp 0", nd); end
    launch(8'h12, 8'h34, 1'b0);
    wait_done(lat, bc2, both, chg, got);
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL midrst_fresh_timeout done=0 after %0d cycles exp pulse at 9", lat);
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      n_tests++; if (sum !== e.sum) begin n_fail++; $display("FAIL midrst_fresh_sum got %h exp %h", sum, e.sum); end
      n_tests++; if (sum !== 8'h46) begin n_fail++; $display("FAIL midrst_fresh_sum_abs got %h exp 46", sum); end
    end
  endtask

  task automatic test_back_to_back();
    int   t = 0, last = -1, nd = 0, nb = 0;
    res_t e;
    @(negedge clk);
    a = 8'h01; b = 8'h01; mode = 1'b0; start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h01, 8'h01, 1'b0));
    for (int i = 0; i < 60 && nd < 3; i++) begin
      @(negedge clk);
      t++;
      if (done) begin
        e = exp_q.pop_front();
        n_tests++; if (sum !== e.sum) begin n_fail++; $display("FAIL b2b_sum[%0d] got %h exp %h", nd, sum, e.sum); end
        if (nd > 0) begin
          n_tests++;
          if (t - last !== 10) begin n_fail++; $display("FAIL b2b_period[%0d] got %0d exp 10", nd, t - last); end
        end
        last = t;
        nd++;
      end
    end
    start = 1'b0;
    n_tests++; if (nd !== 3) begin n_fail++; $display("FAIL b2b_count got %0d pulses exp 3", nd); end
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    n_tests++; if (nb !== 0) begin n_fail++; $display("FAIL b2b_stop got %0d busy cycles exp 0", nb); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Parametrised bit-serial adder/subtractor with a start/busy/done handshake. One full-adder cell is reused over WIDTH clock cycles, LSB first, instead of a ripple chain. It produces a WIDTH-bit result, carry/no-borrow, and signed overflow. It sits behind switch/register front-ends as the arithmetic core for add/sub labs and datapaths.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  request a new operation; sampled only in IDLE.
mode  in  1  0 = add (a+b), 1 = subtract (a-b).
a  in  WIDTH  operand A; captured on the accepted start edge.
b  in  WIDTH  operand B; captured on the accepted start edge.
busy  out  1  high while the operation is in RUN.
done  out  1  one-cycle pulse when the result becomes valid.
sum  out  WIDTH  result bits.
cout  out  1  add: carry out. Sub: no-borrow (1 when a >= b unsigned).
ovf  out  1  signed two's-complement overflow.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0. Reset wins over every other event, including mid-RUN: the operation is aborted and no done pulse is issued.
- IDLE, start=1 at edge k:
  - Latch a into shift reg A and b into shift reg B; for sub, latch ~b.
  - Carry register = mode (carry-in 1 for sub).
  - Counter=0, state->RUN.
- IDLE, start=0: hold. sum/cout/ovf keep the last result.
- RUN, one bit per edge, edges k+1..k+WIDTH:
  - s_i = A0 ^ B0 ^ c; c_next = majority(A0, B0, c).
  - Shift A and B right. Shift s_i into the result register MSB-side so that bit 0 lands at sum[0] after WIDTH shifts.
  - Record carry-into-MSB on the last bit (counter = WIDTH-1).
- End of RUN, edge k+WIDTH:
  - sum, cout = final carry, ovf = carry-into-MSB ^ final carry are all updated together.
  - State->DONE.
- DONE: done=1 for exactly one cycle (the cycle after edge k+WIDTH), then state->IDLE. Latency from accepted start to done high = WIDTH+1 edges.
- busy=1 exactly in RUN (WIDTH cycles). busy and done are never both 1.
- start in RUN or DONE is ignored (not queued). start held high continuously gives back-to-back operations, one per WIDTH+2 cycles.
- sum/cout/ovf do not change during RUN; they reflect the previous result until the new one is committed.
- a/b/mode changes after the accepted start edge have no effect.
- Counter width is $clog2(WIDTH); no wrap occurs because the counter resets on entry to RUN.

Optional Feature:
SERIAL_ADDSUB_SAT_EN.
- Defined: when ovf would be 1, sum is clamped to the signed limit: 0111..1 if the true result is positive (A MSB = 0), 1000..0 if negative. ovf is still reported as 1. cout is unchanged.
- Undefined: sum is the wrapped result; no clamp logic is present.

Decomposition:
- Package serial_addsub_pkg:
  - state typedef (IDLE/RUN/DONE).
  - constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- One sub-module: fa_bit, a single-bit full adder (a, b, ci -> s, co), instantiated once. Its registered carry is held in serial_addsub.

Test Plan (WIDTH=8):
- add 0x0F+0xF0 -> done at start+9 edges; sum=0xFF, cout=0, ovf=0; busy high for exactly 8 cycles.
- add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Then add 0x7F+0x01 -> sum=0x80, cout=0, ovf=1 (sum=0x7F with SERIAL_ADDSUB_SAT_EN).
- sub 0x05-0x07 -> sum=0xFE, cout=0, ovf=0. Then sub 0x80-0x01 -> sum=0x7F, cout=1, ovf=1 (sum=0x80 with SAT_EN).
- start pulsed again at cycle 3 of RUN with different operands -> ignored; first result is delivered intact and no second done pulse follows.
- rst asserted at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done pulse for the aborted operation. A fresh add 0x12+0x34 -> sum=0x46.
- start held high with constant a=0x01, b=0x01, add -> done pulses every 10 cycles, sum=0x02 each time.
